counter_cycle_arbiter: RTL and testbench
========================================

Name: counter_cycle_arbiter

Overview:
- Shares the single counter-increment datapath between NUM_CELLS counter cells, each of which can request a plus or minus count.
- Latches request edges into per-cell pending flags.
- At each instruction-boundary window, grants the highest-priority pending cell one counter cycle.
- Sequences that cycle as CYCLE_LEN numbered timepulses, which drive the NOR-gate datapath.

Parameters:
NUM_CELLS, 8, number of counter cells; index 0 has highest priority
CYCLE_LEN, 12, clocks per counter cycle (timepulses 1..CYCLE_LEN); legal range 2..15
TPW, 4, width of the timepulse output; must satisfy 2^TPW > CYCLE_LEN

Ports:
clk  input  1  single system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
req_plus  input  NUM_CELLS  per-cell plus-count request level (synchronous to clk)
req_minus  input  NUM_CELLS  per-cell minus-count request level (synchronous to clk)
window  input  1  one-clock strobe: the datapath is free at an instruction boundary
inhibit  input  1  when high, windows are ignored; pending flags still accumulate
grant  output  NUM_CELLS  one-hot; identifies the cell being served, zero when idle
grant_plus  output  1  high for the whole cycle when the served count is plus
grant_minus  output  1  high for the whole cycle when the served count is minus
busy  output  1  counter cycle in progress
tp  output  TPW  current timepulse number 1..CYCLE_LEN while busy, 0 when idle
done  output  1  one-clock pulse during the last timepulse of a cycle
pend_plus  output  NUM_CELLS  pending plus flags (visible for debug and verification)
pend_minus  output  NUM_CELLS  pending minus flags

Behaviour:
- Reset: rst high immediately clears all of the following, regardless of clock:
  - pending flags and edge-detect history
  - grant, grant_plus, grant_minus, busy and done
  - tp, which goes to 0
- Reset mid-cycle aborts the cycle. No done pulse is generated and nothing resumes after reset.
- Request capture:
  - A pending flag sets on a rising edge of its request line (line high now, low in the previous clock).
  - Holding a line high produces exactly one request.
  - A flag that is already set absorbs further edges; there is no counting.
- Cancellation: while idle and at a window, a cell with both plus and minus pending has both flags cleared in that clock. No cycle is spent on it and it takes no part in priority that clock.
- Arbitration:
  - Occurs in a clock where window=1, inhibit=0, busy=0 and at least one non-cancelled flag is pending.
  - The winner is the lowest-index cell with a non-cancelled pending flag.
  - Direction: plus if pend_plus is set for that cell, else minus.
  - Windows received while busy or inhibited are dropped, not queued.
- Cycle timing, with arbitration in clock k:
  - Clock k+1: grant, the direction bit and busy all rise; tp=1.
  - tp increments by 1 each clock.
  - Clock k+CYCLE_LEN: tp=CYCLE_LEN and done=1.
  - Clock k+CYCLE_LEN+1: busy, grant and the direction bit are low; tp=0.
- Outputs are registered and hold steady for the whole cycle.
- Flag clearing:
  - The served flag clears on the clock edge that ends the done cycle.
  - If a new rising edge on that same line coincides with the clear, set wins and the flag stays pending.
- Edges on other cells or the other direction during a cycle are captured normally.
- A window in the done clock is ignored. The earliest next arbitration is the clock after busy falls.
- No pending and a window: no action, and outputs stay idle.
- Invariants:
  - grant is always one-hot or zero.
  - grant_plus and grant_minus are never both high.
  - busy equals (tp != 0).

Test Plan:
1. Reset, then a single plus edge on cell 3 and window one clock later -> grant=8'h08 and grant_plus=1 for exactly 12 clocks; tp runs 1..12; done is high only at tp=12; pend_plus[3]=0 afterwards.
2. Plus edges on cells 5 and 2 in the same clock, then windows whenever idle -> cell 2 is served first, cell 5 in the next cycle; a window inside either cycle produces no extra grant.
3. Plus and minus edges on cell 1, then a window -> both flags clear in the window clock; busy stays 0. Repeat with cell 4 plus also pending -> cell 1 cancels and cell 4 is granted in the same arbitration.
4. Cell 0 plus being served, new req_plus[0] edge exactly in its done clock -> pend_plus[0] remains 1 after the cycle and the next window serves it again.
5. inhibit=1 with cells 0 and 7 pending and windows every 5 clocks -> no grant. inhibit=0 -> the next window grants cell 0.
6. Assert rst at tp=6 of a cycle -> all outputs are zero immediately (asynchronously), with no done pulse. After rst is released, a window with no new edges gives no grant.

Source files
------------

// File: rtl/counter_cycle_arbiter.sv
// counter_cycle_arbiter: shares one counter-increment datapath among NUM_CELLS cells,
// granting one CYCLE_LEN-timepulse counter cycle per instruction-boundary window.
module counter_cycle_arbiter #(
  parameter int NUM_CELLS = 8,
  parameter int CYCLE_LEN = 12,
  parameter int TPW       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CELLS-1:0] req_plus,
  input  logic [NUM_CELLS-1:0] req_minus,
  input  logic                 window,
  input  logic                 inhibit,
  output logic [NUM_CELLS-1:0] grant,
  output logic                 grant_plus,
  output logic                 grant_minus,
  output logic                 busy,
  output logic [TPW-1:0]       tp,
  output logic                 done,
  output logic [NUM_CELLS-1:0] pend_plus,
  output logic [NUM_CELLS-1:0] pend_minus
);
  logic [NUM_CELLS-1:0] prev_plus, prev_minus, cancel, elig, win_vec, clr_plus, clr_minus;
  logic arb, last;
  assign busy = tp != '0;
  assign last = tp == TPW'(CYCLE_LEN);
  always_comb begin
    cancel    = (window & ~inhibit & ~busy) ? pend_plus & pend_minus : '0;
    elig      = (pend_plus | pend_minus) & ~cancel;
    win_vec   = elig & (~elig + NUM_CELLS'(1));
    arb       = window & ~inhibit & ~busy & (|elig);
    clr_plus  = cancel | ((last & grant_plus) ? grant : '0);
    clr_minus = cancel | ((last & grant_minus) ? grant : '0);
  end
  // a new request edge coinciding with a clear wins, so the flag stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_plus   <= '0;
      prev_minus  <= '0;
      pend_plus   <= '0;
      pend_minus  <= '0;
      grant       <= '0;
      grant_plus  <= 1'b0;
      grant_minus <= 1'b0;
      tp          <= '0;
      done        <= 1'b0;
    end else begin
      prev_plus  <= req_plus;
      prev_minus <= req_minus;
      pend_plus  <= (pend_plus & ~clr_plus) | (req_plus & ~prev_plus);
      pend_minus <= (pend_minus & ~clr_minus) | (req_minus & ~prev_minus);
      if (busy) begin
        tp   <= last ? '0 : tp + TPW'(1);
        done <= tp == TPW'(CYCLE_LEN - 1);
        if (last) begin
          grant       <= '0;
          grant_plus  <= 1'b0;
          grant_minus <= 1'b0;
        end
      end else if (arb) begin
        grant       <= win_vec;
        grant_plus  <= |(win_vec & pend_plus);
        grant_minus <= ~|(win_vec & pend_plus);
        tp          <= TPW'(1);
      end
    end
  end
endmodule

// File: tb/tb_counter_cycle_arbiter.sv
// tb_counter_cycle_arbiter: directed and random stimulus checked against a
// cycle-level reference model of the arbiter.
module tb_counter_cycle_arbiter;
  localparam int N = 8, CL = 12, TPW = 4;
  logic clk = 0, rst = 1, window = 0, inhibit = 0;
  logic [N-1:0] rp = '0, rm = '0;
  logic [N-1:0] grant, pend_plus, pend_minus;
  logic grant_plus, grant_minus, busy, done;
  logic [TPW-1:0] tp;
  int passed = 0, total = 0;
  logic [N-1:0] mpp, mpm, mprevp, mprevm;
  int mtp, mcell;
  bit mdir;

  counter_cycle_arbiter #(.NUM_CELLS(N), .CYCLE_LEN(CL), .TPW(TPW)) dut (
    .clk(clk), .rst(rst), .req_plus(rp), .req_minus(rm), .window(window), .inhibit(inhibit),
    .grant(grant), .grant_plus(grant_plus), .grant_minus(grant_minus), .busy(busy), .tp(tp),
    .done(done), .pend_plus(pend_plus), .pend_minus(pend_minus));

  always #5 clk = ~clk;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task check_all();
    logic [N-1:0] g;
    g = '0;
    if (mtp != 0) g[mcell] = 1'b1;
    chk("grant", 32'(grant), 32'(g));
    chk("grant_plus", 32'(grant_plus), 32'(mtp != 0 && mdir));
    chk("grant_minus", 32'(grant_minus), 32'(mtp != 0 && !mdir));
    chk("busy", 32'(busy), 32'(mtp != 0));
    chk("tp", 32'(tp), 32'(mtp));
    chk("done", 32'(done), 32'(mtp == CL));
    chk("pend_plus", 32'(pend_plus), 32'(mpp));
    chk("pend_minus", 32'(pend_minus), 32'(mpm));
  endtask

  task model_reset();
    mpp = '0; mpm = '0; mprevp = '0; mprevm = '0; mtp = 0; mcell = 0; mdir = 0;
  endtask

  task model_clock();
    logic [N-1:0] ep, em;
    int w;
    ep = rp & ~mprevp;
    em = rm & ~mprevm;
    if (mtp != 0) begin
      if (mtp == CL) begin
        if (mdir) mpp[mcell] = 1'b0; else mpm[mcell] = 1'b0;
        mtp = 0;
      end else mtp++;
    end else if (window && !inhibit) begin
      for (int c = 0; c < N; c++)
        if (mpp[c] && mpm[c]) begin mpp[c] = 1'b0; mpm[c] = 1'b0; end
      w = -1;
      for (int c = N - 1; c >= 0; c--) if (mpp[c] || mpm[c]) w = c;
      if (w >= 0) begin mcell = w; mdir = mpp[w]; mtp = 1; end
    end
    mpp |= ep;
    mpm |= em;
    mprevp = rp;
    mprevm = rm;
  endtask

  task step(input logic w, input logic inh);
    window = w;
    inhibit = inh;
    @(posedge clk);
    if (rst) model_reset(); else model_clock();
    #1 check_all();
  endtask

  initial begin
    logic [N-1:0] mask;
    model_reset();
    step(0, 0);
    rst = 0;
    // single plus on cell 3
    rp[3] = 1; step(0, 0); rp = '0; step(1, 0);
    repeat (14) step(0, 0);
    // simultaneous cells 5 and 2, windows inside cycles dropped
    rp[5] = 1; rp[2] = 1; step(0, 0); rp = '0; step(1, 0);
    repeat (5) step(0, 0);
    step(1, 0);
    while (mtp != 0) step(0, 0);
    repeat (CL + 3) step(1, 0);
    // cancellation, alone and with another cell pending
    rp[1] = 1; rm[1] = 1; step(0, 0); rp = '0; rm = '0; step(1, 0); step(0, 0);
    rp[1] = 1; rm[1] = 1; rp[4] = 1; step(0, 0); rp = '0; rm = '0; step(1, 0);
    while (mtp != 0) step(0, 0);
    // re-request of the served cell in its done clock
    rp[0] = 1; step(0, 0); rp = '0; step(1, 0);
    while (mtp != CL) step(0, 0);
    rp[0] = 1; step(0, 0);
    chk("t4_pend_kept", 32'(pend_plus[0]), 32'd1);
    rp = '0; step(0, 0); step(1, 0);
    while (mtp != 0) step(0, 0);
    // inhibit drops windows
    rp[0] = 1; rp[7] = 1; step(0, 0); rp = '0;
    repeat (4) begin step(1, 1); repeat (4) step(0, 1); end
    step(1, 0);
    while (mtp != 0) step(0, 0);
    step(1, 0);
    while (mtp != 0) step(0, 0);
    // asynchronous reset mid-cycle
    rm[6] = 1; step(0, 0); rm = '0; step(1, 0);
    while (mtp != 6) step(0, 0);
    #2 rst = 1;
    #1 model_reset();
    check_all();
    @(negedge clk) rst = 0;
    step(1, 0); step(0, 0);
    // random traffic
    repeat (600) begin
      mask = ($urandom_range(0, 2) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
      rp ^= mask;
      mask = ($urandom_range(0, 2) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
      rm ^= mask;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
